// File: rtl/pa_wb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pa_wb_trace_monitor
// Description : Bring-up run controller and writeback tracer for PA_Core.
//               Holds the core in reset until start_i is seen. It then enables
//               the core for exactly RUN_CYCLES cycles. Every writeback seen
//               on NUM_WB_PORTS channels during the run is captured into a
//               DEPTH-entry trace FIFO as {port, addr, value, cycle stamp}.
//               A host drains the FIFO through a pop/valid read port.
// Ports       : clock_i, reset_i (async, active-high)
//               start_i                       begin a run (IDLE/DONE only)
//               wbEn_i / wbAddr_i / wbVal_i   packed per-port writebacks
//               coreReset_o, coreRun_o, done_o  run control to the core
//               rdReq_i -> rdValid_o, rdPort_o, rdAddr_o, rdVal_o, rdCycle_o
//               count_o                       FIFO occupancy
//               overflow_o                    sticky dropped-writeback flag
// Revision    : 1.0 - initial release
// ============================================================================
module pa_wb_trace_monitor #(
    parameter  int NUM_WB_PORTS = 2,
    parameter  int ADDR_W       = 5,
    parameter  int DATA_W       = 16,
    parameter  int DEPTH        = 16,
    parameter  int RUN_CYCLES   = 15,
    localparam int CYC_W        = $clog2(RUN_CYCLES + 1),
    localparam int PORT_W       = (NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic [NUM_WB_PORTS-1:0]        wbEn_i,
    input  logic [NUM_WB_PORTS*ADDR_W-1:0] wbAddr_i,
    input  logic [NUM_WB_PORTS*DATA_W-1:0] wbVal_i,
    output logic                           coreReset_o,
    output logic                           coreRun_o,
    output logic                           done_o,
    input  logic                           rdReq_i,
    output logic                           rdValid_o,
    output logic [PORT_W-1:0]              rdPort_o,
    output logic [ADDR_W-1:0]              rdAddr_o,
    output logic [DATA_W-1:0]              rdVal_o,
    output logic [CYC_W-1:0]               rdCycle_o,
    output logic [CNT_W-1:0]               count_o,
    output logic                           overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [CYC_W-1:0]    r_cycle;
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_coreReset;
    logic                r_coreRun;
    logic                r_done;
    logic                r_rdValid;
    logic [PORT_W-1:0]   r_rdPort;
    logic [ADDR_W-1:0]   r_rdAddr;
    logic [DATA_W-1:0]   r_rdVal;
    logic [CYC_W-1:0]    r_rdCycle;

    logic [PORT_W-1:0]   r_memPort [DEPTH];
    logic [ADDR_W-1:0]   r_memAddr [DEPTH];
    logic [DATA_W-1:0]   r_memVal  [DEPTH];
    logic [CYC_W-1:0]    r_memCyc  [DEPTH];

    logic                    w_runStart;
    logic                    w_lastCycle;
    logic                    w_pop;
    logic                    w_drop;
    logic [CNT_W-1:0]        w_free;
    logic [CNT_W-1:0]        w_pushCnt;
    logic [NUM_WB_PORTS-1:0] w_pushEn;
    logic [PTR_W-1:0]        w_pushIdx [NUM_WB_PORTS];

    // A start is only honoured outside RUN; it clears the trace on the same edge.
    assign w_runStart  = start_i && (r_state != S_RUN);
    assign w_lastCycle = (r_state == S_RUN) && (r_cycle == CYC_W'(RUN_CYCLES - 1));
    // A pop coinciding with a run start would read a trace that is being discarded.
    assign w_pop       = rdReq_i && (r_count != '0) && !w_runStart;

    // ---------------- FSM ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (start_i)     w_nextState = S_RUN;
            S_RUN:          if (w_lastCycle) w_nextState = S_DONE;
            default:                         w_nextState = S_IDLE;
        endcase
    end

    // ---------------- Push allocation ----------------
    // Free space is taken from the occupancy at the start of the cycle, so a
    // concurrent pop never makes room. Ports are granted in ascending order,
    // which means excess requests drop from the highest port downwards.
    always_comb begin
        w_free    = CNT_W'(DEPTH) - r_count;
        w_pushCnt = '0;
        w_pushEn  = '0;
        w_drop    = 1'b0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            w_pushIdx[p] = r_wrPtr + w_pushCnt[PTR_W-1:0];
            if (r_coreRun && wbEn_i[p]) begin
                if (w_pushCnt < w_free) begin
                    w_pushEn[p] = 1'b1;
                    w_pushCnt   = w_pushCnt + CNT_W'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // ---------------- Trace storage ----------------
    always_ff @(posedge clock_i) begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (w_pushEn[p]) begin
                r_memPort[w_pushIdx[p]] <= PORT_W'(p);
                r_memAddr[w_pushIdx[p]] <= wbAddr_i[p*ADDR_W +: ADDR_W];
                r_memVal[w_pushIdx[p]]  <= wbVal_i[p*DATA_W +: DATA_W];
                r_memCyc[w_pushIdx[p]]  <= r_cycle;
            end
        end
    end

    // ---------------- Control, pointers and read port ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_coreReset <= 1'b1;
            r_coreRun   <= 1'b0;
            r_done      <= 1'b0;
            r_cycle     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_rdValid   <= 1'b0;
            r_rdPort    <= '0;
            r_rdAddr    <= '0;
            r_rdVal     <= '0;
            r_rdCycle   <= '0;
        end else begin
            // Core controls are registered copies of the next state.
            r_coreReset <= (w_nextState == S_IDLE);
            r_coreRun   <= (w_nextState == S_RUN);
            r_done      <= (w_nextState == S_DONE);

            if (w_runStart) begin
                r_cycle    <= '0;
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_cycle <= r_cycle + CYC_W'(1);
                end
                r_wrPtr <= r_wrPtr + w_pushCnt[PTR_W-1:0];
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                r_count <= r_count + w_pushCnt - CNT_W'(w_pop);
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end

            r_rdValid <= w_pop;
            if (w_pop) begin
                r_rdPort  <= r_memPort[r_rdPtr];
                r_rdAddr  <= r_memAddr[r_rdPtr];
                r_rdVal   <= r_memVal[r_rdPtr];
                r_rdCycle <= r_memCyc[r_rdPtr];
            end
        end
    end

    assign coreReset_o = r_coreReset;
    assign coreRun_o   = r_coreRun;
    assign done_o      = r_done;
    assign rdValid_o   = r_rdValid;
    assign rdPort_o    = r_rdPort;
    assign rdAddr_o    = r_rdAddr;
    assign rdVal_o     = r_rdVal;
    assign rdCycle_o   = r_rdCycle;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pa_wb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_wb_trace_monitor
// Description : Directed self-checking bench for pa_wb_trace_monitor. A small
//               reference model tracks run state, occupancy and overflow; a
//               scoreboard queue holds expected trace entries as writebacks
//               are driven and is popped when the read port returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_wb_trace_monitor;

    localparam int NP    = 2;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int RUNC  = 15;
    localparam int CYC_W = $clog2(RUNC + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        int port;
        int addr;
        int val;
        int cyc;
    } entry_t;

    logic              clock_i  = 1'b0;
    logic              reset_i  = 1'b1;
    logic              start_i  = 1'b0;
    logic              rdReq_i  = 1'b0;
    logic [NP-1:0]     wbEn_i   = '0;
    logic [NP*AW-1:0]  wbAddr_i = '0;
    logic [NP*DW-1:0]  wbVal_i  = '0;
    logic              coreReset_o;
    logic              coreRun_o;
    logic              done_o;
    logic              rdValid_o;
    logic [0:0]        rdPort_o;
    logic [AW-1:0]     rdAddr_o;
    logic [DW-1:0]     rdVal_o;
    logic [CYC_W-1:0]  rdCycle_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;

    int     checks = 0;
    int     errors = 0;
    entry_t q[$];
    int     mState = 0;   // 0 idle, 1 run, 2 done
    int     mCycle = 0;
    int     mOvf   = 0;
    int     runs;

    pa_wb_trace_monitor #(
        .NUM_WB_PORTS (NP),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .RUN_CYCLES   (RUNC)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .wbEn_i      (wbEn_i),
        .wbAddr_i    (wbAddr_i),
        .wbVal_i     (wbVal_i),
        .coreReset_o (coreReset_o),
        .coreRun_o   (coreRun_o),
        .done_o      (done_o),
        .rdReq_i     (rdReq_i),
        .rdValid_o   (rdValid_o),
        .rdPort_o    (rdPort_o),
        .rdAddr_o    (rdAddr_o),
        .rdVal_o     (rdVal_o),
        .rdCycle_o   (rdCycle_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setWb(input int p, input int addr, input int val);
        wbEn_i[p]             = 1'b1;
        wbAddr_i[p*AW +: AW]  = AW'(addr);
        wbVal_i[p*DW +: DW]   = DW'(val);
    endtask

    task automatic clearWb();
        wbEn_i   = '0;
        wbAddr_i = '0;
        wbVal_i  = '0;
    endtask

    task automatic modelReset();
        q.delete();
        mState = 0;
        mCycle = 0;
        mOvf   = 0;
    endtask

    // Advance one clock: update the model from the driven inputs, then check
    // every output 1 time unit after the rising edge.
    task automatic step();
        bit     expValid;
        bit     startNow;
        entry_t pend;
        int     freeSp;
        int     pushed;
        entry_t e;
        pend     = '{0, 0, 0, 0};
        expValid = 1'b0;
        startNow = start_i && (mState != 1);
        if (rdReq_i && q.size() > 0 && !startNow) begin
            expValid = 1'b1;
            pend     = q.pop_front();
        end
        if (mState == 1) begin
            freeSp = DEPTH - (q.size() + int'(expValid));
            pushed = 0;
            for (int p = 0; p < NP; p++) begin
                if (wbEn_i[p]) begin
                    if (pushed < freeSp) begin
                        e.port = p;
                        e.addr = int'(wbAddr_i[p*AW +: AW]);
                        e.val  = int'(wbVal_i[p*DW +: DW]);
                        e.cyc  = mCycle;
                        q.push_back(e);
                        pushed++;
                    end else begin
                        mOvf = 1;
                    end
                end
            end
            if (mCycle == RUNC - 1) mState = 2;
            else                    mCycle++;
        end else if (startNow) begin
            mState = 1;
            mCycle = 0;
            mOvf   = 0;
            q.delete();
        end
        @(posedge clock_i);
        #1;
        chk("coreReset", 32'(coreReset_o), 32'(mState == 0));
        chk("coreRun",   32'(coreRun_o),   32'(mState == 1));
        chk("done",      32'(done_o),      32'(mState == 2));
        chk("count",     32'(count_o),     32'(q.size()));
        chk("overflow",  32'(overflow_o),  32'(mOvf));
        chk("rdValid",   32'(rdValid_o),   32'(expValid));
        if (expValid && rdValid_o) begin
            chk("rdPort",  32'(rdPort_o),  32'(pend.port));
            chk("rdAddr",  32'(rdAddr_o),  32'(pend.addr));
            chk("rdVal",   32'(rdVal_o),   32'(pend.val));
            chk("rdCycle", 32'(rdCycle_o), 32'(pend.cyc));
        end
    endtask

    task automatic drain(input int n);
        rdReq_i = 1'b1;
        repeat (n + 1) step();
        rdReq_i = 1'b0;
    endtask

    task automatic startRun();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        // ---- reset and idle ----
        repeat (2) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        modelReset();
        chk("rstRdPort",  32'(rdPort_o),  32'd0);
        chk("rstRdAddr",  32'(rdAddr_o),  32'd0);
        chk("rstRdVal",   32'(rdVal_o),   32'd0);
        chk("rstRdCycle", 32'(rdCycle_o), 32'd0);
        repeat (5) step();

        // ---- empty run: coreRun_o for exactly RUNC cycles ----
        startRun();
        runs = coreRun_o ? 1 : 0;
        for (int i = 0; i < 40 && !done_o; i++) begin
            step();
            if (coreRun_o) runs++;
        end
        chk("runLength", 32'(runs), 32'(RUNC));
        chk("emptyRunCount", 32'(count_o), 32'd0);

        // ---- dual writeback at cycle 3 ----
        startRun();
        for (int c = 0; c < RUNC; c++) begin
            clearWb();
            if (c == 3) begin
                setWb(0, 4, 'hBEEF);
                setWb(1, 9, 'h0012);
            end
            step();
        end
        clearWb();
        chk("dualCount", 32'(count_o), 32'd2);
        drain(2);

        // ---- fill to exactly DEPTH, no overflow ----
        startRun();
        for (int c = 0; c < RUNC; c++) begin
            clearWb();
            setWb(0, c, 'h1000 + c);
            if (c == 14) setWb(1, 20, 'hB014);
            step();
        end
        clearWb();
        chk("fullCount", 32'(count_o), 32'(DEPTH));
        chk("fullNoOvf", 32'(overflow_o), 32'd0);
        drain(DEPTH);

        // ---- one request beyond DEPTH: highest port dropped ----
        startRun();
        for (int c = 0; c < RUNC; c++) begin
            clearWb();
            setWb(0, 31 - c, 'h2000 + c);
            if (c >= 13) setWb(1, c, 'hB000 + c);
            step();
        end
        clearWb();
        chk("ovfCount", 32'(count_o), 32'(DEPTH));
        chk("ovfSet",   32'(overflow_o), 32'd1);
        // partial drain, then a start with a pop pending discards the rest
        rdReq_i = 1'b1;
        repeat (3) step();

        // ---- streaming: pop every cycle, push on even cycles ----
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < RUNC; c++) begin
            clearWb();
            if (c % 2 == 0) setWb(0, c, 'h3000 + c * 7);
            step();
            chk("streamCountLe1", 32'(count_o <= 1), 32'd1);
        end
        clearWb();
        step();
        rdReq_i = 1'b0;

        // ---- asynchronous reset mid-run ----
        startRun();
        for (int c = 0; c < 7; c++) begin
            clearWb();
            if (c < 4) setWb(0, c + 1, 'h4000 + c);
            step();
        end
        clearWb();
        chk("preResetCount", 32'(count_o), 32'd4);
        #3;
        reset_i = 1'b1;
        #1;
        modelReset();
        chk("asyncCoreReset", 32'(coreReset_o), 32'd1);
        chk("asyncCoreRun",   32'(coreRun_o),   32'd0);
        chk("asyncDone",      32'(done_o),      32'd0);
        chk("asyncCount",     32'(count_o),     32'd0);
        chk("asyncRdValid",   32'(rdValid_o),   32'd0);
        chk("asyncRdVal",     32'(rdVal_o),     32'd0);
        step();
        reset_i = 1'b0;
        step();

        // ---- fresh run after reset: stamps restart at 0 ----
        startRun();
        chk("freshCount", 32'(count_o), 32'd0);
        for (int c = 0; c < RUNC; c++) begin
            clearWb();
            if (c == 0 || c == 2) setWb(0, 7 + c, 'h5A00 + c);
            step();
        end
        clearWb();
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
